// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and defaults for the data-memory access block
// Purpose: FSM state encoding, default geometry/latency, counter sizing helper.
// Ports: none (package).
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } dmem_state_e;

  localparam int DEPTH_WORDS_DEF = 64;
  localparam int LATENCY_DEF     = 2;

  // Counter must hold LATENCY-1; keep at least one bit so LATENCY=1 still builds.
  function automatic int cnt_width(input int latency);
    return (latency > 1) ? $clog2(latency) : 1;
  endfunction

endpackage

// File: rtl/dmem_if.sv
// rtl/dmem_if.sv - memory-stage request/response bundle between pipeline and dmem
// Purpose: groups the load/store request and the stall/done/data response.
// Ports (master = pipeline side):
//   memread_m, memwrite_m, addr_m, wdata_m : request from the EX/MEM register
//   rdata_w                                : load data toward MEM/WB
//   stall_m, done, err_misaligned          : access status
interface dmem_if;
  logic        memread_m;
  logic        memwrite_m;
  logic [31:0] addr_m;
  logic [31:0] wdata_m;
  logic [31:0] rdata_w;
  logic        stall_m;
  logic        done;
  logic        err_misaligned;

  modport master (
    output memread_m, memwrite_m, addr_m, wdata_m,
    input  rdata_w, stall_m, done, err_misaligned
  );

  modport slave (
    input  memread_m, memwrite_m, addr_m, wdata_m,
    output rdata_w, stall_m, done, err_misaligned
  );
endinterface

// File: rtl/dmem_ram.sv
// rtl/dmem_ram.sv - single-port data RAM, synchronous write, combinational read
// Purpose: DEPTH_WORDS x 32 storage; contents survive reset.
// Ports:
//   clk   : clock
//   we    : write enable (word written on rising edge)
//   addr  : word index
//   wdata : write data
//   rdata : read data for addr (combinational)
module dmem_ram #(
  parameter int DEPTH_WORDS = 64,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dmem_access.sv
// rtl/dmem_access.sv - multi-cycle data-memory access with pipeline stall
// Purpose: accepts one load/store from the memory stage, stalls the pipeline
//   for LATENCY+1 cycles, performs the access and pulses done.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous, active-high
//   bus   : dmem_if slave (request in; rdata_w, stall_m, done, err_misaligned out)
module dmem_access
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = DEPTH_WORDS_DEF,
  parameter int LATENCY     = LATENCY_DEF
) (
  input  logic   clk,
  input  logic   reset,
  dmem_if.slave  bus
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = cnt_width(LATENCY);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_WAIT = WAIT;
  localparam logic [1:0] ST_DONE = DONE;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [AW-1:0] idx_q;
  logic          mis_q;
  logic [31:0]   wdata_q;
  logic          op_wr_q;
  logic          op_rd_q;
  logic [31:0]   rdata_q;
  logic [31:0]   ram_rdata;
  logic          req;
  logic          access_now;
  logic          ram_we;

  // Bits above the word index are deliberately ignored (address wrap).
  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, bus.addr_m[31:AW+2]};

  assign req        = bus.memread_m | bus.memwrite_m;
  assign access_now = (state == ST_WAIT) && (cnt == '0);
  // Reset on the final WAIT edge must drop the store.
  assign ram_we     = access_now && op_wr_q && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      idx_q   <= '0;
      mis_q   <= 1'b0;
      wdata_q <= '0;
      op_wr_q <= 1'b0;
      op_rd_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req) begin
            idx_q   <= bus.addr_m[AW+1:2];
            mis_q   <= (bus.addr_m[1:0] != 2'b00);
            wdata_q <= bus.wdata_m;
            op_wr_q <= bus.memwrite_m;
            // A simultaneous read+write is treated as a store only.
            op_rd_q <= bus.memread_m & ~bus.memwrite_m;
            cnt     <= CW'(LATENCY - 1);
            state   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt == '0) begin
            if (op_rd_q) begin
              rdata_q <= ram_rdata;
            end
            state <= ST_DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_DONE: begin
          // The EX/MEM register still holds the finished request here.
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  dmem_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (idx_q),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  // Stall rises combinationally in the accepting IDLE cycle.
  assign bus.stall_m        = ((state == ST_IDLE) && req) || (state == ST_WAIT);
  assign bus.done           = (state == ST_DONE);
  assign bus.err_misaligned = (state == ST_DONE) && mis_q;
  assign bus.rdata_w        = rdata_q;

endmodule

// File: tb/tb_dmem_access.sv
// tb/tb_dmem_access.sv - directed self-checking bench for dmem_access
module tb_dmem_access;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  dmem_if bus ();

  dmem_access #(
    .DEPTH_WORDS (64),
    .LATENCY     (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Called 1ns after a rising edge; returns 1ns after the edge that follows DONE.
  task automatic run_access(input logic rd, input logic wr, input logic [31:0] a,
                            input logic [31:0] d, output int n_stall, output int done_at,
                            output logic err_at, output logic [31:0] rdata_at);
    bus.memread_m  = rd;
    bus.memwrite_m = wr;
    bus.addr_m     = a;
    bus.wdata_m    = d;
    n_stall  = 0;
    done_at  = -1;
    err_at   = 1'b0;
    rdata_at = '0;
    #1;
    for (int c = 0; c < 20; c++) begin
      if (bus.stall_m) n_stall++;
      if (bus.done) begin
        done_at  = c;
        err_at   = bus.err_misaligned;
        rdata_at = bus.rdata_w;
        break;
      end
      @(posedge clk);
      #1;
      if (c == 0) begin
        bus.memread_m  = 1'b0;
        bus.memwrite_m = 1'b0;
        bus.addr_m     = 32'hFFFF_FFFF;
      end
      #1;
    end
    @(posedge clk);
    #1;
  endtask

  int          ns;
  int          da;
  logic        er;
  logic [31:0] rv;
  logic [7:0]  stall_seen;
  logic [7:0]  done_seen;
  logic [31:0] rd3;
  logic [31:0] rd7;
  int          done_cnt;

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.memread_m  = 1'b0;
    bus.memwrite_m = 1'b0;
    bus.addr_m     = '0;
    bus.wdata_m    = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_stall", {31'b0, bus.stall_m}, 32'd0);
    check("rst_done", {31'b0, bus.done}, 32'd0);
    check("rst_err", {31'b0, bus.err_misaligned}, 32'd0);
    check("rst_rdata", bus.rdata_w, 32'd0);

    // Store then load
    run_access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, ns, da, er, rv);
    check("st_stall_cycles", ns, 32'd3);
    check("st_done_cycle", da, 32'd3);
    check("st_rdata_unchanged", rv, 32'd0);
    run_access(1'b1, 1'b0, 32'h10, 32'h0, ns, da, er, rv);
    check("ld_stall_cycles", ns, 32'd3);
    check("ld_done_cycle", da, 32'd3);
    check("ld_rdata", rv, 32'hDEADBEEF);
    check("ld_err", {31'b0, er}, 32'd0);

    // Address wrap
    run_access(1'b0, 1'b1, 32'h100, 32'h12345678, ns, da, er, rv);
    run_access(1'b1, 1'b0, 32'h000, 32'h0, ns, da, er, rv);
    check("wrap_rdata", rv, 32'h12345678);

    // Misaligned load
    run_access(1'b0, 1'b1, 32'h10, 32'hA5A5A5A5, ns, da, er, rv);
    run_access(1'b1, 1'b0, 32'h13, 32'h0, ns, da, er, rv);
    check("mis_rdata", rv, 32'hA5A5A5A5);
    check("mis_err_done", {31'b0, er}, 32'd1);
    check("mis_err_after", {31'b0, bus.err_misaligned}, 32'd0);

    // Simultaneous read and write
    run_access(1'b0, 1'b1, 32'h24, 32'h1, ns, da, er, rv);
    run_access(1'b1, 1'b0, 32'h24, 32'h0, ns, da, er, rv);
    check("rw_pre_rdata", rv, 32'h1);
    run_access(1'b1, 1'b1, 32'h20, 32'h55, ns, da, er, rv);
    check("rw_rdata_kept", rv, 32'h1);
    check("rw_done_cycle", da, 32'd3);
    run_access(1'b1, 1'b0, 32'h20, 32'h0, ns, da, er, rv);
    check("rw_word8", rv, 32'h55);

    // Reset during a store
    run_access(1'b0, 1'b1, 32'h40, 32'h7, ns, da, er, rv);
    bus.memwrite_m = 1'b1;
    bus.addr_m     = 32'h40;
    bus.wdata_m    = 32'hFFFF0000;
    @(posedge clk);
    #1;
    reset = 1'b1;
    bus.memwrite_m = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_st_stall", {31'b0, bus.stall_m}, 32'd0);
    done_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      if (bus.done) done_cnt++;
      @(posedge clk);
      #1;
    end
    check("rst_st_no_done", done_cnt, 32'd0);
    run_access(1'b1, 1'b0, 32'h40, 32'h0, ns, da, er, rv);
    check("rst_st_ram_kept", rv, 32'h7);

    // Reset during a load
    bus.memread_m = 1'b1;
    bus.addr_m    = 32'h40;
    @(posedge clk);
    #1;
    reset = 1'b1;
    bus.memread_m = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_ld_stall", {31'b0, bus.stall_m}, 32'd0);
    check("rst_ld_rdata", bus.rdata_w, 32'd0);

    // Back-to-back loads: request held through DONE, address changed mid-WAIT
    bus.memread_m = 1'b1;
    bus.addr_m    = 32'h24;
    stall_seen = '0;
    done_seen  = '0;
    rd3 = '0;
    rd7 = '0;
    for (int c = 0; c < 8; c++) begin
      #1;
      stall_seen[c] = bus.stall_m;
      done_seen[c]  = bus.done;
      if (c == 3) rd3 = bus.rdata_w;
      if (c == 7) rd7 = bus.rdata_w;
      @(posedge clk);
      #1;
      if (c == 0) bus.addr_m = 32'h10;
    end
    bus.memread_m = 1'b0;
    check("b2b_stall", {24'b0, stall_seen}, 32'h77);
    check("b2b_done", {24'b0, done_seen}, 32'h88);
    check("b2b_rdata1", rd3, 32'h1);
    check("b2b_rdata2", rd7, 32'hA5A5A5A5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_access.md
DMEM_ACCESS -- requirements
Module: dmem_access

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 64, number of 32-bit words in the data RAM; it must be a power of two.
REQ-002 The block SHALL have parameter LATENCY, default 2, number of WAIT cycles per access; it must be at least 1.
REQ-003 The block SHALL have port clk, input, 1 bit, the clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit, reset; synchronous, active-high.
REQ-005 The block SHALL have port memread_m, input, 1 bit, memory-stage load request.
REQ-006 The block SHALL have port memwrite_m, input, 1 bit, memory-stage store request.
REQ-007 The block SHALL have port addr_m, input, 32 bits, byte address (ALU result from the EX/MEM register).
REQ-008 The block SHALL have port wdata_m, input, 32 bits, store data from the EX/MEM register.
REQ-009 The block SHALL have port rdata_w, output, 32 bits, load data presented to the MEM/WB register.
REQ-010 The block SHALL have port stall_m, output, 1 bit, freeze request; the pipeline drives pipeline-register enables with ~stall_m.
REQ-011 The block SHALL have port done, output, 1 bit, one-cycle pulse marking access completion.
REQ-012 The block SHALL have port err_misaligned, output, 1 bit, one-cycle pulse in the DONE cycle when addr[1:0] != 0.

Function
REQ-013 The block SHALL implement the FSM states IDLE, WAIT and DONE.
REQ-014 IDLE: when memread_m or memwrite_m is 1, the block SHALL do all of the following:
- latch the address, the data and the operation;
- load the counter with LATENCY-1;
- drive stall_m=1 combinationally in that same cycle;
- go to WAIT.
REQ-015 IDLE with no request: the block SHALL stay in IDLE with stall_m=0.
REQ-016 WAIT: the block SHALL hold stall_m=1 and decrement the counter each cycle.
REQ-017 WAIT with counter==0: the block SHALL perform the latched access on that clock edge and go to DONE.
- Store: write the latched data to the RAM.
- Load: capture the RAM word into rdata_w.
REQ-018 DONE: the block SHALL drive stall_m=0 and done=1, and go to IDLE unconditionally.
- No request is accepted in DONE, because the EX/MEM register still holds the completed request.
REQ-019 stall_m SHALL be high for exactly LATENCY+1 consecutive cycles per access, and done SHALL pulse LATENCY+1 cycles after the request is first seen.
REQ-020 If memread_m and memwrite_m are both 1, the block SHALL perform a store only and leave rdata_w unchanged.
REQ-021 The word index SHALL be addr[log2(DEPTH_WORDS)+1:2]; higher address bits are ignored, so addresses wrap modulo 4*DEPTH_WORDS bytes.
REQ-022 For a misaligned address, the block SHALL access the aligned word (ignoring addr[1:0]) and pulse err_misaligned in DONE.
REQ-023 rdata_w SHALL hold its value between loads, and stores SHALL NOT modify it.
REQ-024 The block SHALL sample request inputs only in IDLE; changes to them during WAIT or DONE SHALL be ignored.

Reset
REQ-025 When reset=1 at a clock edge, the block SHALL do all of the following, with reset taking priority over all other events:
- go to IDLE;
- clear the counter and the latches;
- set rdata_w=0, done=0 and err_misaligned=0.
REQ-026 stall_m SHALL be 0 in the cycle following the reset edge.
REQ-027 A reset asserted during WAIT SHALL abort the access.
- A pending store is dropped and RAM is not written.
- A pending load leaves rdata_w=0.
REQ-028 RAM contents SHALL NOT be cleared by reset.

Structure
REQ-029 Package dmem_pkg SHALL hold the state enum (IDLE, WAIT, DONE), DEPTH_WORDS_DEF=64 and LATENCY_DEF=2.
REQ-030 The RAM SHALL be sub-module dmem_ram: single port, synchronous write, combinational read, DEPTH_WORDS x 32, no reset.
REQ-031 The FSM, counter and latches SHALL reside in dmem_access.

Verification
REQ-032 Bench scenario, store then load (LATENCY=2):
- Stimulus: store 0xDEADBEEF to 0x10, then load from 0x10.
- Required response: each access holds stall_m high for 3 cycles and pulses done in the 4th cycle; the load gives rdata_w=0xDEADBEEF.
REQ-033 Bench scenario, address wrap:
- Stimulus: store 0x12345678 to 0x100 with DEPTH_WORDS=64, then load from 0x000.
- Required response: rdata_w=0x12345678.
REQ-034 Bench scenario, misaligned load:
- Stimulus: load from 0x13 with word 4 = 0xA5A5A5A5.
- Required response: rdata_w=0xA5A5A5A5 and err_misaligned=1 for one cycle in DONE.
REQ-035 Bench scenario, simultaneous read and write:
- Stimulus: rdata_w=0x1, then memread_m=memwrite_m=1 with wdata 0x55 to 0x20.
- Required response: word 8 becomes 0x55 and rdata_w stays 0x1.
REQ-036 Bench scenario, reset mid-access:
- Stimulus: store 0xFFFF0000 to 0x40 (word 0x40 previously 0x7), with reset pulsed in the first WAIT cycle.
- Required response: stall_m=0 the next cycle, done never pulses, and a later load from 0x40 returns 0x7.
REQ-037 Bench scenario, back-to-back requests:
- Stimulus: memread_m held high through DONE.
- Required response: exactly one access completes per DONE, and the next request is accepted in the following IDLE cycle.
